// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
// -------------
// Issue/write-back controller that sits around an iterative unsigned divider
// and owns the HI/LO architectural registers.
//
// Requests from the pipeline (DIV/DIVU) are reduced to operand magnitudes,
// and the controller then pulses the divider start. After the divider
// latency it sign-corrects the quotient/remainder and commits them to
// LO/HI. The pipeline is stalled while a division is in flight. MTHI/MTLO
// writes are serviced only while idle.
//
// Parameters:
//   DIV_CYCLES : cycles from div_start until div_q/div_r are valid (>= 1)
//   WIDTH      : operand/result width
//
// Ports:
//   clock, reset              : clock; synchronous active-high reset
//   op_valid, op_signed       : DIV/DIVU request, 1 = signed (DIV)
//   rs_val, rt_val            : dividend, divisor
//   mthi, mtlo, wdata         : HI/LO move-to writes
//   div_dividend, div_divisor : magnitude operands to the divider
//   div_start                 : one-cycle divider start pulse
//   div_q, div_r              : unsigned quotient/remainder from the divider
//   hi, lo                    : HI (remainder) and LO (quotient) registers
//   stall                     : high while a division is in flight
//   done                      : one-cycle pulse in the cycle HI/LO commit
//   div_zero_exc              : (HILO_DIV_ZERO_TRAP_EN only) zero-divisor trap
//
// Optional feature macro: HILO_DIV_ZERO_TRAP_EN
//   defined   : a zero divisor raises div_zero_exc for one cycle and leaves
//               HI/LO untouched.
//   undefined : a zero divisor completes in one cycle with lo = all ones,
//               hi = dividend, and pulses done.

module hilo_div_ctrl #(
  parameter int DIV_CYCLES = 33,
  parameter int WIDTH      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_start,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             done
`ifdef HILO_DIV_ZERO_TRAP_EN
  ,
  output logic             div_zero_exc
`endif
);

  // The wait counter only has to reach DIV_CYCLES-1.
  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    FIX
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;

  // Operand magnitudes: only signed requests with a negative operand are
  // negated. Negation is plain two's complement, so the most negative value
  // maps onto itself, which the unsigned divider treats as 2^(WIDTH-1).
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  always_comb begin
    rs_neg = op_signed & rs_val[WIDTH-1];
    rt_neg = op_signed & rt_val[WIDTH-1];
    rs_mag = rs_neg ? -rs_val : rs_val;
    rt_mag = rt_neg ? -rt_val : rt_val;
  end

  // Single controller process. div_start, done and the trap flag are
  // single-cycle pulses, cleared by default and set on the edge that enters
  // the cycle they belong to. stall is registered alongside the state so it
  // is high exactly while state != IDLE. Reset abandons any in-flight
  // division; its result is never committed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_start    <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      stall        <= 1'b0;
      done         <= 1'b0;
`ifdef HILO_DIV_ZERO_TRAP_EN
      div_zero_exc <= 1'b0;
`endif
    end else begin
      div_start <= 1'b0;
      done      <= 1'b0;
`ifdef HILO_DIV_ZERO_TRAP_EN
      div_zero_exc <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Move-to writes land first; a division accepted in the same
          // cycle overwrites HI/LO later.
          if (mthi) begin
            hi <= wdata;
          end
          if (mtlo) begin
            lo <= wdata;
          end
          if (op_valid) begin
            if (rt_val != '0) begin
              sign_q       <= op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              sign_r       <= op_signed & rs_val[WIDTH-1];
              div_dividend <= rs_mag;
              div_divisor  <= rt_mag;
              div_start    <= 1'b1;
              stall        <= 1'b1;
              state        <= START;
            end else begin
`ifdef HILO_DIV_ZERO_TRAP_EN
              div_zero_exc <= 1'b1;
`else
              // Zero divisor resolves in place; the divider is not started.
              lo   <= '1;
              hi   <= rs_val;
              done <= 1'b1;
`endif
            end
          end
        end

        START: begin
          cnt   <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (cnt == CNT_LAST) begin
            done  <= 1'b1;
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        FIX: begin
          lo    <= sign_q ? -div_q : div_q;
          hi    <= sign_r ? -div_r : div_r;
          stall <= 1'b0;
          state <= IDLE;
        end

        default: begin
          stall <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl
// ----------------
// Self-checking bench for hilo_div_ctrl. A behavioural divider answers
// div_start with garbage until DIV_CYCLES cycles have passed, then with the
// true unsigned quotient/remainder. Expected HI/LO commits are queued when a
// request is driven and compared when the DUT pulses done.

module tb_hilo_div_ctrl;

  localparam int DC = 33;
  localparam int W  = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_signed = 1'b0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic         div_start;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         stall;
  logic         done;
`ifdef HILO_DIV_ZERO_TRAP_EN
  logic         div_zero_exc;
`endif

  hilo_div_ctrl #(
    .DIV_CYCLES(DC),
    .WIDTH(W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .op_valid(op_valid),
    .op_signed(op_signed),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .mthi(mthi),
    .mtlo(mtlo),
    .wdata(wdata),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_start(div_start),
    .div_q(div_q),
    .div_r(div_r),
    .hi(hi),
    .lo(lo),
    .stall(stall),
    .done(done)
`ifdef HILO_DIV_ZERO_TRAP_EN
    ,
    .div_zero_exc(div_zero_exc)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  int           acc_cyc = 0;
  logic [63:0]  pend_res = '0;

  // Count rising edges so latencies can be expressed in cycles.
  always @(posedge clock) cyc <= cyc + 1;

  // Divider model: valid DC cycles after the start pulse, garbage before.
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           age = 0;
  logic         busy = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      age  <= 0;
    end else if (div_start) begin
      m_a  <= div_dividend;
      m_b  <= div_divisor;
      age  <= 1;
      busy <= 1'b1;
    end else if (busy) begin
      age <= age + 1;
    end
  end

  always_comb begin
    div_q = 32'hBAD0_BAD0;
    div_r = 32'hBAD1_BAD1;
    if (busy && age >= DC && m_b != '0) begin
      div_q = m_a / m_b;
      div_r = m_a % m_b;
    end
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Reference result {hi, lo} using 64-bit host arithmetic (truncating).
  function automatic logic [63:0] divModel(input logic sgn, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint na, nb, q, r;
    if (sgn) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Scoreboard consumer: on done, pop the expectation, check the cycle, and
  // compare HI/LO one cycle later once the commit is visible.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("done_cycle", cyc, e.cyc);
        @(negedge clock);
        checkOutput("sb_lo", lo, e.lo);
        checkOutput("sb_hi", hi, e.hi);
      end
    end
  end

  // Drive one request for a single cycle and check the cycle after accept.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] rs,
                               input logic [W-1:0] rt, input logic mh,
                               input logic ml, input logic [W-1:0] wd);
    logic [W-1:0] mag_a, mag_b;
    @(negedge clock);
    op_valid  = 1'b1;
    op_signed = sgn;
    rs_val    = rs;
    rt_val    = rt;
    mthi      = mh;
    mtlo      = ml;
    wdata     = wd;
    acc_cyc   = cyc;
    if (mh) exp_hi = wd;
    if (ml) exp_lo = wd;
    if (rt != '0) begin
      pend_res = divModel(sgn, rs, rt);
      sb.push_back('{hi: pend_res[63:32], lo: pend_res[31:0], cyc: acc_cyc + 2 + DC});
    end else begin
`ifndef HILO_DIV_ZERO_TRAP_EN
      sb.push_back('{hi: rs, lo: 32'hFFFF_FFFF, cyc: acc_cyc + 1});
`endif
    end
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    mthi     = 1'b0;
    mtlo     = 1'b0;
    @(negedge clock);
    if (rt != '0) begin
      mag_a = (sgn && rs[W-1]) ? (~rs + 1) : rs;
      mag_b = (sgn && rt[W-1]) ? (~rt + 1) : rt;
      checkOutput("div_start", div_start, 1);
      checkOutput("stall_rise", stall, 1);
      checkOutput("div_dividend", div_dividend, mag_a);
      checkOutput("div_divisor", div_divisor, mag_b);
      if (mh) checkOutput("mt_hi_same_cycle", hi, wd);
      if (ml) checkOutput("mt_lo_same_cycle", lo, wd);
    end else begin
      checkOutput("zero_no_start", div_start, 0);
      checkOutput("zero_no_stall", stall, 0);
`ifdef HILO_DIV_ZERO_TRAP_EN
      checkOutput("div_zero_exc", div_zero_exc, 1);
      checkOutput("zero_hi_kept", hi, exp_hi);
      checkOutput("zero_lo_kept", lo, exp_lo);
`else
      exp_hi = rs;
      exp_lo = 32'hFFFF_FFFF;
      checkOutput("zero_done", done, 1);
      checkOutput("zero_hi", hi, exp_hi);
      checkOutput("zero_lo", lo, exp_lo);
`endif
    end
  endtask

  // Wait (bounded) for the division to retire and check stall length.
  task automatic finishOp();
    int n = 0;
    while (stall && n < 2 * DC + 20) begin
      @(negedge clock);
      n++;
    end
    if (stall) checkOutput("stall_timeout", 1, 0);
    else checkOutput("stall_cycles", cyc - acc_cyc - 1, DC + 2);
    exp_hi = pend_res[63:32];
    exp_lo = pend_res[31:0];
    @(negedge clock);
    checkOutput("hi_final", hi, exp_hi);
    checkOutput("lo_final", lo, exp_lo);
  endtask

  task automatic runDiv(input logic sgn, input logic [W-1:0] rs, input logic [W-1:0] rt);
    applyStimulus(sgn, rs, rt, 1'b0, 1'b0, '0);
    finishOp();
  endtask

  task automatic doMt(input logic mh, input logic ml, input logic [W-1:0] wd);
    @(negedge clock);
    mthi  = mh;
    mtlo  = ml;
    wdata = wd;
    if (mh) exp_hi = wd;
    if (ml) exp_lo = wd;
    @(posedge clock);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    @(negedge clock);
    checkOutput("mt_hi", hi, exp_hi);
    checkOutput("mt_lo", lo, exp_lo);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] rr, rt;
    logic         sg;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_div_start", div_start, 0);
    checkOutput("rst_dividend", div_dividend, 0);
    checkOutput("rst_divisor", div_divisor, 0);

    $display("[TB] DIVU 100/7");
    runDiv(1'b0, 32'd100, 32'd7);

    $display("[TB] DIV -7/2");
    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2);

    $display("[TB] DIV 0x80000000/-1");
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    $display("[TB] DIV 7/-3 and DIVU of negative-looking operands");
    runDiv(1'b1, 32'd7, 32'hFFFF_FFFD);
    runDiv(1'b0, 32'hFFFF_FFF9, 32'd2);

    $display("[TB] MTHI with DIVU 9/4, MTLO and op_valid mid-division");
    applyStimulus(1'b0, 32'd9, 32'd4, 1'b1, 1'b0, 32'h0000_DEAD);
    repeat (5) @(negedge clock);
    op_valid = 1'b1;
    op_signed = 1'b0;
    rs_val = 32'd50;
    rt_val = 32'd5;
    mtlo = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    mtlo = 1'b0;
    @(negedge clock);
    checkOutput("mtlo_ignored", lo, exp_lo);
    checkOutput("stall_held", stall, 1);
    finishOp();

    $display("[TB] MTHI+MTLO together");
    doMt(1'b1, 1'b1, 32'hCAFE_F00D);
    doMt(1'b0, 1'b1, 32'h0000_0042);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, 32'd50, 32'd6, 1'b0, 1'b0, '0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clock);
    checkOutput("rst_wait_stall", stall, 0);
    checkOutput("rst_wait_hi", hi, 0);
    checkOutput("rst_wait_lo", lo, 0);
    checkOutput("rst_wait_done", done, 0);
    exp_hi = '0;
    exp_lo = '0;
    repeat (DC + 5) @(negedge clock);
    runDiv(1'b0, 32'd10, 32'd3);

    $display("[TB] divide by zero");
    applyStimulus(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clock);
    checkOutput("zero_after_hi", hi, exp_hi);
    checkOutput("zero_after_lo", lo, exp_lo);

    $display("[TB] random divisions");
    for (int i = 0; i < 6; i++) begin
      sg = 1'(i % 2);
      rr = $urandom;
      rt = (i < 3) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 2) rt = ~rt + 1;
      if (rt == '0) rt = 32'd1;
      runDiv(sg, rr, rt);
    end

    repeat (3) @(negedge clock);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Issue/write-back controller that wraps the iterative unsigned divider.
- Upstream role: accepts signed or unsigned DIV operations and converts the operands to magnitudes. It then pulses the divider start.
- Downstream role: waits the divider latency, sign-corrects the quotient and remainder, and commits them to the HI/LO architectural registers.
- Stalls the pipeline while a division is in flight. Also services MTHI/MTLO writes.

Parameters:
- DIV_CYCLES, 33, number of clock cycles from the divider start pulse until div_q/div_r are valid (minimum 1).
- WIDTH, 32, operand/result width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  DIV/DIVU request this cycle.
- op_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- rs_val  in  WIDTH  dividend.
- rt_val  in  WIDTH  divisor.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- div_dividend  out  WIDTH  magnitude dividend to the divider.
- div_divisor  out  WIDTH  magnitude divisor to the divider.
- div_start  out  1  one-cycle start pulse to the divider.
- div_q  in  WIDTH  unsigned quotient from the divider.
- div_r  in  WIDTH  unsigned remainder from the divider.
- hi  out  WIDTH  HI register (remainder).
- lo  out  WIDTH  LO register (quotient).
- stall  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse in the cycle HI/LO are committed.

Behaviour:
- Reset: synchronous, active-high, effective at the next rising edge regardless of state. All outputs go to 0 and the state returns to IDLE. An in-flight division is abandoned and its result is never committed.

State machine:
- IDLE
  - op_valid=1 and rt_val!=0: latch sign_q = op_signed & (rs[31]^rt[31]) and sign_r = op_signed & rs[31].
  - Latch div_dividend = (op_signed & rs[31]) ? -rs : rs, and div_divisor likewise from rt.
  - Go to START.
- START
  - div_start=1 for exactly this cycle.
  - Cycle counter cleared to 0.
  - Go to WAIT.
- WAIT
  - Counter increments each cycle.
  - Leave when the counter equals DIV_CYCLES-1; go to FIX.
- FIX
  - lo <= sign_q ? -div_q : div_q
  - hi <= sign_r ? -div_r : div_r
  - done=1 for this cycle.
  - Go to IDLE.

Latency and stall:
- Accept edge at T. div_start is high in cycle T+1.
- HI/LO are updated at the end of cycle T+2+DIV_CYCLES. done is high in that cycle.
- stall rises in the cycle after accept and falls after FIX.

Operand hold and drop rules:
- div_dividend and div_divisor are held stable from START through FIX.
- op_valid while state != IDLE is ignored; the pipeline is already stalled.
- mthi/mtlo while state != IDLE are ignored.

MTHI/MTLO in IDLE:
- Write on the next edge.
- If op_valid is also high in the same cycle, the MT write happens and the division is still accepted. The division later overwrites HI/LO.
- mthi and mtlo both high: both registers take wdata.

Arithmetic:
- All negation is two's complement, truncated to WIDTH.
- 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.

Divide by zero (rt_val=0 with op_valid in IDLE):
- The divider is not started.
- The behaviour is set by the optional feature below.

Optional Feature:
- Macro: HILO_DIV_ZERO_TRAP_EN.
- Defined:
  - Adds output div_zero_exc (1 bit).
  - div_zero_exc pulses high for one cycle, the cycle after the zero-divisor request.
  - HI/LO are unchanged, stall stays low, done stays low.
- Not defined:
  - The zero-divisor request completes in one cycle.
  - On the next edge: lo <= 0xFFFFFFFF, hi <= rs_val.
  - done pulses in the following cycle.
  - No divider start is issued.

Test Plan:
- DIVU rs=100, rt=7 with DIV_CYCLES=33 -> div_start pulse at T+1, stall high 35 cycles, then lo=14, hi=2, done pulse.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> div_dividend=7, div_divisor=2; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi wdata=0xDEAD in the same cycle as DIVU 9/4 -> hi=0xDEAD next cycle, then hi=1, lo=2 at done. An mtlo issued mid-division is ignored.
- Reset asserted in WAIT -> next edge: stall=0, hi=lo=0, no done pulse. A new DIVU 10/3 then gives lo=3, hi=1.
- Divide by zero (rs=5, rt=0):
  - Macro defined -> div_zero_exc pulse, HI/LO unchanged.
  - Macro undefined -> lo=0xFFFFFFFF, hi=5, no div_start.
